// File: rtl/inst_encoder_if.sv
// inst_encoder_if
// Bundles the encoder's field-set input handshake, its output FIFO
// handshake and the statistics counters.
//   slave  : the encoder side (consumes fields, produces words)
//   master : the driver side (produces fields, consumes words)
// Signals:
//   in_valid_i/in_ready_o     field-set handshake
//   type_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i   decoded fields
//   out_valid_o/out_ready_i   FIFO head handshake
//   inst_o, err_o             encoded word and error flag at FIFO head
//   cnt_ok_o, cnt_err_o       saturating accepted-word counters
interface inst_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       type_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      imm_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic             err_o;
    logic [CNT_W-1:0] cnt_ok_o;
    logic [CNT_W-1:0] cnt_err_o;

    modport slave (
        input  in_valid_i, type_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i,
               imm_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, err_o, cnt_ok_o, cnt_err_o
    );

    modport master (
        output in_valid_i, type_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i,
               imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, err_o, cnt_ok_o, cnt_err_o
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder
// Packs decoded RISC-V fields (R / I / LOAD / STORE / BRANCH) into a 32-bit
// instruction word, flags immediates that cannot be represented, and queues
// {word, err} in a small circular FIFO.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  synchronous active-high reset
//   bus    inst_encoder_if.slave (fields in, words out, counters)
module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    inst_encoder_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0]      r_mem_inst [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_word;
    logic               w_err;
    logic signed [31:0] w_imm_s;

    // Ready comes only from registered occupancy, so a full FIFO refuses a
    // push even when the head is popped in the same cycle.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;
    assign w_imm_s     = $signed(bus.imm_i);

    // Field scattering; out-of-range immediates still have their low bits
    // packed so the word remains a faithful truncation.
    always_comb begin
        w_word = 32'h0000_0013;
        w_err  = 1'b1;
        case (bus.type_i)
            3'd0: begin
                w_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i,
                          bus.rd_i, OP_R};
                w_err  = 1'b0;
            end
            3'd1, 3'd2: begin
                w_word = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i,
                          (bus.type_i == 3'd1) ? OP_I : OP_LOAD};
                w_err  = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
            end
            3'd3: begin
                w_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                          bus.imm_i[4:0], OP_STORE};
                w_err  = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
            end
            3'd4: begin
                w_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i,
                          bus.funct3_i, bus.imm_i[4:1], bus.imm_i[11],
                          OP_BRANCH};
                w_err  = bus.imm_i[0] || (w_imm_s < -32'sd4096) ||
                         (w_imm_s > 32'sd4094);
            end
            default: begin
                w_word = 32'h0000_0013;
                w_err  = 1'b1;
            end
        endcase
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem_inst[r_wr_ptr] <= w_word;
            r_mem_err[r_wr_ptr]  <= w_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_err) begin
                    if (r_cnt_err != '1) begin
                        r_cnt_err <= r_cnt_err + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt_ok != '1) begin
                        r_cnt_ok <= r_cnt_ok + CNT_W'(1);
                    end
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.inst_o      = w_out_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign bus.err_o       = w_out_valid ? r_mem_err[r_rd_ptr] : 1'b0;
    assign bus.cnt_ok_o    = r_cnt_ok;
    assign bus.cnt_err_o   = r_cnt_err;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
// Directed plus randomized stimulus for inst_encoder, compared every cycle
// against a queue-based reference model that encodes words arithmetically.
module tb_inst_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    inst_encoder_if #(.CNT_W(CNT_W)) bus ();

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } ent_t;

    ent_t q[$];
    int   m_ok;
    int   m_err;
    int   n_pass;
    int   n_total;

    function automatic logic [32:0] ref_enc(input logic [2:0] t,
                                            input logic [4:0] rd,
                                            input logic [4:0] rs1,
                                            input logic [4:0] rs2,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input int         imm);
        logic [31:0] u;
        logic [31:0] regs;
        logic [31:0] w;
        logic        e;
        u    = imm;
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        case (t)
            3'd0: begin
                w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
                e = 1'b0;
            end
            3'd1, 3'd2: begin
                w = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7) |
                    ((t == 3'd1) ? 32'h13 : 32'h03);
                e = (imm < -2048) || (imm > 2047);
            end
            3'd3: begin
                w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs |
                    ((u & 32'h1F) << 7) | 32'h23;
                e = (imm < -2048) || (imm > 2047);
            end
            3'd4: begin
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                    (32'(rs2) << 20) | regs | (((u >> 1) & 32'hF) << 8) |
                    (((u >> 11) & 32'h1) << 7) | 32'h63;
                e = ((imm % 2) != 0) || (imm < -4096) || (imm > 4094);
            end
            default: begin
                w = 32'h13;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input logic v, input logic [2:0] t, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input int imm);
        bus.in_valid_i = v;
        bus.type_i     = t;
        bus.rd_i       = rd;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.funct3_i   = f3;
        bus.funct7_i   = f7;
        bus.imm_i      = imm;
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(bus.in_ready_o), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid_o), 32'(q.size() > 0));
        chk("inst", bus.inst_o, (q.size() > 0) ? q[0].inst : 32'h0);
        chk("err", 32'(bus.err_o), (q.size() > 0) ? 32'(q[0].err) : 32'h0);
        chk("cnt_ok", 32'(bus.cnt_ok_o), m_ok);
        chk("cnt_err", 32'(bus.cnt_err_o), m_err);
    endtask

    // One clock: decide what the model accepts from pre-edge state, advance
    // the model after the edge, then compare all outputs.
    task automatic tick();
        logic        do_push;
        logic        do_pop;
        logic [32:0] e;
        ent_t        ent;
        do_push = bus.in_valid_i && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && bus.out_ready_i;
        e = ref_enc(bus.type_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.funct3_i,
                    bus.funct7_i, int'($signed(bus.imm_i)));
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            q.delete();
            m_ok  = 0;
            m_err = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                ent.inst = e[31:0];
                ent.err  = e[32];
                q.push_back(ent);
                if (e[32]) begin
                    if (m_err < CNT_MAX) m_err++;
                end else begin
                    if (m_ok < CNT_MAX) m_ok++;
                end
            end
        end
        check_outputs();
    endtask

    function automatic int pick_imm();
        int bnd[10] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096, -1};
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 8191)) - 4096;
            1:       return bnd[$urandom_range(0, 9)];
            2:       return int'($urandom);
            default: return 2 * (int'($urandom_range(0, 4095)) - 2048);
        endcase
    endfunction

    initial begin
        logic [32:0] ea;
        logic [32:0] eb;
        logic [32:0] ec;
        logic [31:0] w;
        logic [11:0] bf;
        n_pass  = 0;
        n_total = 0;
        m_ok    = 0;
        m_err   = 0;

        rst_i = 1'b1;
        bus.out_ready_i = 1'b0;
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // R then I, held in the FIFO
        set_in(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0);
        tick();
        chk("r_word", bus.inst_o, 32'h002081B3);
        chk("r_first_valid", 32'(bus.out_valid_o), 32'h1);
        set_in(1'b1, 3'd1, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, -1);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        bus.out_ready_i = 1'b1;
        tick();
        chk("i_word", bus.inst_o, 32'hFFF08293);
        chk("i_err", 32'(bus.err_o), 32'h0);
        tick();
        chk("cnt_ok_two", 32'(bus.cnt_ok_o), 32'd2);

        // STORE and BRANCH, streaming with out_ready high
        set_in(1'b1, 3'd3, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 8);
        tick();
        chk("store_word", bus.inst_o, 32'h0021A423);
        set_in(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -4);
        tick();
        chk("branch_word", bus.inst_o, 32'hFE208EE3);
        w  = bus.inst_o;
        bf = {w[31], w[7], w[30:25], w[11:8]};
        chk("branch_decode", 32'(int'($signed(bf)) * 2), 32'hFFFF_FFFC);

        // Encoding errors
        set_in(1'b1, 3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048);
        tick();
        chk("i2048_field", 32'(bus.inst_o[31:20]), 32'h800);
        chk("i2048_err", 32'(bus.err_o), 32'h1);
        set_in(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3);
        tick();
        chk("br_odd_err", 32'(bus.err_o), 32'h1);
        set_in(1'b1, 3'd7, 5'd9, 5'd9, 5'd9, 3'd5, 7'd9, 77);
        tick();
        chk("illegal_word", bus.inst_o, 32'h00000013);
        chk("illegal_err", 32'(bus.err_o), 32'h1);
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        tick();
        chk("cnt_err_three", 32'(bus.cnt_err_o), 32'd3);
        chk("cnt_ok_four", 32'(bus.cnt_ok_o), 32'd4);

        // Backpressure: third word must be held until space frees up
        ea = ref_enc(3'd1, 5'd1, 5'd4, 5'd0, 3'd0, 7'd0, 10);
        eb = ref_enc(3'd1, 5'd2, 5'd4, 5'd0, 3'd0, 7'd0, 20);
        ec = ref_enc(3'd1, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 30);
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 3'd1, 5'd1, 5'd4, 5'd0, 3'd0, 7'd0, 10);
        tick();
        set_in(1'b1, 3'd1, 5'd2, 5'd4, 5'd0, 3'd0, 7'd0, 20);
        tick();
        chk("bp_full_ready", 32'(bus.in_ready_o), 32'h0);
        set_in(1'b1, 3'd1, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 30);
        tick();
        chk("bp_head_a", bus.inst_o, ea[31:0]);
        bus.out_ready_i = 1'b1;
        tick();
        chk("bp_head_b", bus.inst_o, eb[31:0]);
        tick();
        chk("bp_head_c", bus.inst_o, ec[31:0]);
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        tick();
        chk("bp_drained", 32'(bus.out_valid_o), 32'h0);

        // Reset with two words queued and nonzero counters
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 3'd0, 5'd7, 5'd8, 5'd9, 3'd1, 7'd32, 0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'h1);
        chk("rst_cnt_ok", 32'(bus.cnt_ok_o), 32'h0);
        chk("rst_cnt_err", 32'(bus.cnt_err_o), 32'h0);
        ea = ref_enc(3'd2, 5'd6, 5'd2, 5'd0, 3'd3, 7'd0, -16);
        set_in(1'b1, 3'd2, 5'd6, 5'd2, 5'd0, 3'd3, 7'd0, -16);
        tick();
        chk("post_rst_word", bus.inst_o, ea[31:0]);
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        bus.out_ready_i = 1'b1;
        tick();

        // Randomized traffic, including counter saturation and rare resets
        for (int i = 0; i < 800; i++) begin
            rst_i = ($urandom_range(0, 79) == 0);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            set_in(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                   5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                   7'($urandom), pick_imm());
            tick();
        end
        rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
